// File: rtl/gpr_wport_arbiter.sv
// Arbitrates the single GPR write port between MEM/WB writeback and queued mul/div results.
// WB always wins; mul/div results wait in a small FIFO and drain in WB bubbles.
module gpr_wport_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        gpr_we,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        pipe_stall
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [StW-1:0]   starve_q, starve_d;

  logic             gpr_we_q, gpr_we_d;
  logic [4:0]       gpr_waddr_q, gpr_waddr_d;
  logic [31:0]      gpr_wdata_q, gpr_wdata_d;
  logic             pipe_stall_q, pipe_stall_d;

  logic             fifo_empty;
  logic             wb_win;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] live;
  logic [PtrW-1:0]  offs;

  assign fifo_empty = (count_q == '0);
  assign md_ready   = (count_q < CntW'(DEPTH));
  // A WB write to r0 is a no-op, so it leaves the port free for the FIFO.
  assign wb_win     = wb_we & (wb_addr != 5'd0);
  // r0 results are accepted (handshake completes) but never stored.
  assign push       = md_valid & md_ready & (md_addr != 5'd0);
  assign pop        = ~wb_win & ~fifo_empty;

  // An entry is live if its distance from head is below the occupancy.
  always_comb begin
    live = '0;
    offs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs    = PtrW'(i) - head_q;
      live[i] = ({1'b0, offs} < count_q);
    end
  end

  always_comb begin
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live[i] && !kill_q[i]) begin
        if (addr_q[i] == id_rs && id_rs != 5'd0) rs_busy = 1'b1;
        if (addr_q[i] == id_rt && id_rt != 5'd0) rt_busy = 1'b1;
      end
    end
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    kill_d = kill_q;
    // WB is younger than anything queued, so a matching queued write is stale.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live[i] && wb_win && addr_q[i] == wb_addr) kill_d[i] = 1'b1;
    end
    if (push) begin
      addr_d[tail_q] = md_addr;
      data_d[tail_q] = md_data;
      kill_d[tail_q] = 1'b0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PtrW'(1);
    if (pop)  head_d = head_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (wb_win && starve_q != StW'(STARVE_MAX)) begin
      starve_d = starve_q + StW'(1);
    end
    pipe_stall_d = (starve_d == StW'(STARVE_MAX));
  end

  always_comb begin
    gpr_we_d    = 1'b0;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    if (wb_win) begin
      gpr_we_d    = 1'b1;
      gpr_waddr_d = wb_addr;
      gpr_wdata_d = wb_data;
    end else if (!fifo_empty) begin
      gpr_we_d    = ~kill_q[head_q];
      gpr_waddr_d = addr_q[head_q];
      gpr_wdata_d = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
      kill_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      gpr_we_q     <= 1'b0;
      gpr_waddr_q  <= 5'd0;
      gpr_wdata_q  <= 32'd0;
      pipe_stall_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      kill_q       <= kill_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      gpr_we_q     <= gpr_we_d;
      gpr_waddr_q  <= gpr_waddr_d;
      gpr_wdata_q  <= gpr_wdata_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  assign gpr_we     = gpr_we_q;
  assign gpr_waddr  = gpr_waddr_q;
  assign gpr_wdata  = gpr_wdata_q;
  assign pipe_stall = pipe_stall_q;

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Directed bench for gpr_wport_arbiter: WB priority, FIFO drain, WAW kill, starvation, reset.
module tb_gpr_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        rs_busy;
  logic        rt_busy;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        pipe_stall;

  int total = 0;
  int bad   = 0;

  gpr_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .md_valid  (md_valid),
    .md_addr   (md_addr),
    .md_data   (md_data),
    .md_ready  (md_ready),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .gpr_we    (gpr_we),
    .gpr_waddr (gpr_waddr),
    .gpr_wdata (gpr_wdata),
    .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  task automatic md(input logic v, input logic [4:0] a, input logic [31:0] d);
    md_valid = v; md_addr = a; md_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    md(1'b1, 5'd5, 32'h1234);
    id_rs = 5'd5;
    id_rt = 5'd0;

    // 1: reset holds everything idle even with md_valid high
    tick(); tick();
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
    chk("rst_gpr_we", {31'd0, gpr_we}, 32'd0);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_rs_busy", {31'd0, rs_busy}, 32'd0);
    chk("rst_waddr", {27'd0, gpr_waddr}, 32'd0);
    md(1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_nopush", {31'd0, rs_busy}, 32'd0);

    // 2: single md result drains in an idle cycle
    md(1'b1, 5'd5, 32'h1234);
    tick();
    md(1'b0, 5'd0, 32'd0);
    chk("t2_busy1", {31'd0, rs_busy}, 32'd1);
    chk("t2_we_lat", {31'd0, gpr_we}, 32'd0);
    tick();
    chk("t2_we", {31'd0, gpr_we}, 32'd1);
    chk("t2_waddr", {27'd0, gpr_waddr}, 32'd5);
    chk("t2_wdata", gpr_wdata, 32'h0000_1234);
    chk("t2_busy0", {31'd0, rs_busy}, 32'd0);
    tick();
    chk("t2_idle_we", {31'd0, gpr_we}, 32'd0);
    chk("t2_hold_waddr", {27'd0, gpr_waddr}, 32'd5);

    // 3: continuous WB starves two queued results
    wb(1'b1, 5'd1, 32'h101);
    md(1'b1, 5'd9, 32'h9999);
    tick();
    chk("t3_ready1", {31'd0, md_ready}, 32'd1);
    chk("t3_wb1", {27'd0, gpr_waddr}, 32'd1);
    wb(1'b1, 5'd2, 32'h102);
    md(1'b1, 5'd10, 32'hA0A0);
    tick();
    chk("t3_ready_full", {31'd0, md_ready}, 32'd0);
    md(1'b1, 5'd11, 32'hBBBB);  // offered to a full FIFO, must not enter
    wb(1'b1, 5'd3, 32'h103);
    tick();
    md(1'b0, 5'd0, 32'd0);
    wb(1'b1, 5'd4, 32'h104);
    tick();
    chk("t3_stall_3lost", {31'd0, pipe_stall}, 32'd0);
    wb(1'b1, 5'd5, 32'h105);
    tick();
    chk("t3_stall_4lost", {31'd0, pipe_stall}, 32'd1);
    for (int r = 6; r <= 8; r++) begin
      wb(1'b1, 5'(r), 32'h100 + 32'(r));
      tick();
    end
    chk("t3_wb8", {27'd0, gpr_waddr}, 32'd8);
    chk("t3_stall_held", {31'd0, pipe_stall}, 32'd1);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk("t3_pop9_we", {31'd0, gpr_we}, 32'd1);
    chk("t3_pop9_addr", {27'd0, gpr_waddr}, 32'd9);
    chk("t3_pop9_data", gpr_wdata, 32'h9999);
    chk("t3_stall_drop", {31'd0, pipe_stall}, 32'd0);
    wb(1'b1, 5'd1, 32'h201);
    tick();
    chk("t3_wb_between", gpr_wdata, 32'h201);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk("t3_pop10_addr", {27'd0, gpr_waddr}, 32'd10);
    chk("t3_pop10_data", gpr_wdata, 32'hA0A0);
    tick();
    chk("t3_no_r11", {31'd0, gpr_we}, 32'd0);

    // 4: WAW kill of a queued r7 by a younger WB write
    id_rt = 5'd7;
    wb(1'b1, 5'd2, 32'h302);
    md(1'b1, 5'd7, 32'hAAAA);
    tick();
    md(1'b0, 5'd0, 32'd0);
    chk("t4_rt_busy", {31'd0, rt_busy}, 32'd1);
    wb(1'b1, 5'd7, 32'h5555);
    tick();
    chk("t4_wb_we", {31'd0, gpr_we}, 32'd1);
    chk("t4_wb_data", gpr_wdata, 32'h5555);
    chk("t4_rt_killed", {31'd0, rt_busy}, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk("t4_pop_killed", {31'd0, gpr_we}, 32'd0);
    chk("t4_pop_waddr", {27'd0, gpr_waddr}, 32'd7);
    // Same-cycle push to the WB address is not killed
    wb(1'b1, 5'd7, 32'h77);
    md(1'b1, 5'd7, 32'hBEEF);
    tick();
    md(1'b0, 5'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    chk("t4_same_busy", {31'd0, rt_busy}, 32'd1);
    tick();
    chk("t4_same_we", {31'd0, gpr_we}, 32'd1);
    chk("t4_same_data", gpr_wdata, 32'hBEEF);

    // 5: r0 results discarded; WB to r0 lets the FIFO pop
    md(1'b1, 5'd0, 32'hFFFF);
    tick();
    md(1'b0, 5'd0, 32'd0);
    chk("t5_r0_ready", {31'd0, md_ready}, 32'd1);
    tick();
    chk("t5_r0_nowrite", {31'd0, gpr_we}, 32'd0);
    wb(1'b1, 5'd4, 32'h404);
    md(1'b1, 5'd3, 32'h3333);
    tick();
    md(1'b0, 5'd0, 32'd0);
    chk("t5_wb4", {27'd0, gpr_waddr}, 32'd4);
    wb(1'b1, 5'd0, 32'hDEAD);
    tick();
    chk("t5_pop3_we", {31'd0, gpr_we}, 32'd1);
    chk("t5_pop3_addr", {27'd0, gpr_waddr}, 32'd3);
    chk("t5_pop3_data", gpr_wdata, 32'h3333);

    // 6: async reset with a full, stalled FIFO
    id_rs = 5'd12;
    wb(1'b1, 5'd1, 32'h501);
    md(1'b1, 5'd12, 32'hC0C0);
    tick();
    wb(1'b1, 5'd2, 32'h502);
    md(1'b1, 5'd13, 32'hD0D0);
    tick();
    md(1'b0, 5'd0, 32'd0);
    for (int r = 3; r <= 5; r++) begin
      wb(1'b1, 5'(r), 32'h500 + 32'(r));
      tick();
    end
    chk("t6_pre_stall", {31'd0, pipe_stall}, 32'd1);
    chk("t6_pre_full", {31'd0, md_ready}, 32'd0);
    chk("t6_pre_busy", {31'd0, rs_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", {31'd0, gpr_we}, 32'd0);
    chk("t6_rst_waddr", {27'd0, gpr_waddr}, 32'd0);
    chk("t6_rst_wdata", gpr_wdata, 32'd0);
    chk("t6_rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("t6_rst_ready", {31'd0, md_ready}, 32'd1);
    chk("t6_rst_busy", {31'd0, rs_busy}, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_we1", {31'd0, gpr_we}, 32'd0);
    tick();
    chk("t6_post_we2", {31'd0, gpr_we}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
